// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: assembles LSB-first characters from sampler strobes into a
// one-entry valid/ready buffer, flagging inter-bit timeouts and buffer overruns.
module rx_frame_ctrl #(
  parameter int unsigned SAMPLE_RATIO = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned TIMEOUT      = 2 * SAMPLE_RATIO
) (
  input  logic                 sample_clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 din,
  input  logic                 sample_sig,
  input  logic                 clear_status,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_timeout,
  output logic                 busy
);

  localparam int unsigned       TimerW   = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerOne = TimerW'(1);
  localparam logic [3:0]        LastBit  = 4'(DATA_BITS - 1);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e                state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_timeout_q, frame_timeout_d;
  logic [DATA_BITS-1:0]  shifted;
  logic                  complete;

  assign shifted = {din, shift_q[DATA_BITS-1:1]};

  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    timer_d         = timer_q;
    frame_timeout_d = 1'b0;
    complete        = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = 4'd0;
        timer_d   = '0;
        if (enable && sample_sig) begin
          shift_d   = shifted;
          bit_cnt_d = 4'd1;
          state_d   = StCollect;
        end
      end
      StCollect: begin
        if (!enable) begin
          state_d   = StIdle;
          bit_cnt_d = 4'd0;
          timer_d   = '0;
        end else if (sample_sig) begin
          // A strobe beats a simultaneous timer expiry.
          shift_d = shifted;
          timer_d = '0;
          if (bit_cnt_q == LastBit) begin
            complete  = 1'b1;
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timer_q == TimerMax) begin
          frame_timeout_d = 1'b1;
          state_d         = StIdle;
          bit_cnt_d       = 4'd0;
          timer_d         = '0;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;

    if (clear_status) begin
      overrun_d = 1'b0;
    end

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shifted;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      shift_q         <= '0;
      bit_cnt_q       <= 4'd0;
      timer_q         <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      overrun_q       <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      timer_q         <= timer_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      overrun_q       <= overrun_d;
      frame_timeout_q <= frame_timeout_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign overrun       = overrun_q;
  assign frame_timeout = frame_timeout_q;
  assign busy          = (state_q == StCollect);

endmodule
